nn_host_tx: RTL



---
 rtl/nn_host_tx.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/nn_host_tx.sv
// ---------------------------------------------------------------------------
// nn_host_tx: buffers one host frame, then replays it as contiguous NN bursts
// and returns the NN result (or a timeout) to the host.       Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nn_host_tx #(
  parameter int W1_WORDS = 12,
  parameter int W2_WORDS = 3,
  parameter int D_WORDS  = 4,
  parameter int T_WORDS  = 1,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_weights,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        in_valid_w1,
  output logic        in_valid_w2,
  output logic        in_valid_d,
  output logic        in_valid_t,
  output logic [31:0] weight1,
  output logic [31:0] weight2,
  output logic [31:0] data_point,
  output logic [31:0] target,
  input  logic        out_valid,
  input  logic [31:0] out,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [31:0] r_data,
  output logic        r_timeout,
  output logic        weights_loaded,
  output logic        err_spurious
);

  localparam int WFRAME = W1_WORDS + W2_WORDS;
  localparam int SFRAME = D_WORDS + T_WORDS;
  localparam int DEPTH  = (WFRAME > SFRAME) ? WFRAME : SFRAME;
  localparam int IDX_W  = $clog2(DEPTH + 1);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] W_A_LAST = IDX_W'(W1_WORDS - 1);
  localparam logic [IDX_W-1:0] S_A_LAST = IDX_W'(D_WORDS - 1);
  localparam logic [IDX_W-1:0] W_F_LAST = IDX_W'(WFRAME - 1);
  localparam logic [IDX_W-1:0] S_F_LAST = IDX_W'(SFRAME - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    SEND_A   = 3'd2,
    SEND_B   = 3'd3,
    WAIT_OUT = 3'd4,
    RESP     = 3'd5
  } state_t;

  state_t           state, next_state;
  logic             is_w, next_is_w;
  logic [IDX_W-1:0] idx, next_idx;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic [31:0]      mem [DEPTH];
  logic [IDX_W-1:0] a_last, f_last;
  logic             capture, tmo_hit, set_wl;
  logic             nxt_a, nxt_b;
  logic [31:0]      send_word;

  assign cmd_ready = (state == IDLE) && !rst;
  assign s_ready   = (state == COLLECT);
  assign r_valid   = (state == RESP);

  assign a_last = is_w ? W_A_LAST : S_A_LAST;
  assign f_last = is_w ? W_F_LAST : S_F_LAST;

  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_cnt   = cnt;
    next_is_w  = is_w;
    capture    = 1'b0;
    tmo_hit    = 1'b0;
    set_wl     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          next_is_w  = cmd_weights;
          next_idx   = '0;
          next_state = COLLECT;
        end
      end
      COLLECT: begin
        if (s_valid) begin
          if (idx == f_last) begin
            next_idx   = '0;
            next_state = SEND_A;
          end else begin
            next_idx = idx + IDX_W'(1);
          end
        end
      end
      SEND_A: begin
        next_idx = idx + IDX_W'(1);
        if (idx == a_last) next_state = SEND_B;
      end
      SEND_B: begin
        if (idx == f_last) begin
          if (is_w) begin
            set_wl     = 1'b1;
            next_state = IDLE;
          end else begin
            next_cnt   = '0;
            next_state = WAIT_OUT;
          end
        end else begin
          next_idx = idx + IDX_W'(1);
        end
      end
      WAIT_OUT: begin
        // A result arriving on the final timeout cycle still counts as a result.
        if (out_valid) begin
          capture    = 1'b1;
          next_state = RESP;
        end else if (cnt == TO_LAST) begin
          tmo_hit    = 1'b1;
          next_state = RESP;
        end else begin
          next_cnt = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        if (r_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NN outputs are registered from the next-state view so bursts leave no gap.
  assign nxt_a     = (next_state == SEND_A);
  assign nxt_b     = (next_state == SEND_B);
  assign send_word = mem[next_idx];

  always_ff @(posedge clk) begin
    if (state == COLLECT && s_valid) mem[idx] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      is_w           <= 1'b0;
      idx            <= '0;
      cnt            <= '0;
      in_valid_w1    <= 1'b0;
      in_valid_w2    <= 1'b0;
      in_valid_d     <= 1'b0;
      in_valid_t     <= 1'b0;
      weight1        <= '0;
      weight2        <= '0;
      data_point     <= '0;
      target         <= '0;
      r_data         <= '0;
      r_timeout      <= 1'b0;
      weights_loaded <= 1'b0;
      err_spurious   <= 1'b0;
    end else begin
      state       <= next_state;
      is_w        <= next_is_w;
      idx         <= next_idx;
      cnt         <= next_cnt;
      in_valid_w1 <= nxt_a && is_w;
      in_valid_w2 <= nxt_b && is_w;
      in_valid_d  <= nxt_a && !is_w;
      in_valid_t  <= nxt_b && !is_w;
      weight1     <= (nxt_a && is_w)  ? send_word : 32'd0;
      weight2     <= (nxt_b && is_w)  ? send_word : 32'd0;
      data_point  <= (nxt_a && !is_w) ? send_word : 32'd0;
      target      <= (nxt_b && !is_w) ? send_word : 32'd0;
      if (capture) begin
        r_data    <= out;
        r_timeout <= 1'b0;
      end else if (tmo_hit) begin
        r_data    <= '0;
        r_timeout <= 1'b1;
      end
      if (set_wl) weights_loaded <= 1'b1;
      if (out_valid && state != WAIT_OUT) err_spurious <= 1'b1;
    end
  end

endmodule

`default_nettype wire
